// File: rtl/fft_pkg.sv
// Shared FFT helpers: sample width, default frame length, log2 and index bit reversal.
package fft_pkg;

  localparam int unsigned FFT_SAMPLE_W  = 16;
  localparam int unsigned FFT_DEFAULT_N = 16;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  function automatic int unsigned fft_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned fft_bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((v >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational W-bit address reversal used to undo radix-2 DIF output ordering.
module fft_bitrev_addr #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] addr_in,
  output logic [W-1:0] addr_out
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign addr_out[i] = addr_in[W-1-i];
  end

endmodule

// File: rtl/fft_frame_reorder.sv
// Ping-pong frame buffer replaying each N-point complex frame in natural order,
// or bit-reversed order when FFT_REORDER_BITREV_EN is defined.
module fft_frame_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = FFT_DEFAULT_N,
  parameter int unsigned DATA_W   = FFT_SAMPLE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_push,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              in_stall,
  output logic              out_push,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_last,
  input  logic              out_stall
);

  localparam int unsigned       LOG2_N   = fft_clog2(N_POINTS);
  localparam int unsigned       SAMP_W   = 2 * DATA_W;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

  logic [SAMP_W-1:0] mem_q [2][N_POINTS];

  logic              wr_bank_q, wr_bank_d;
  logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2_N-1:0] rd_ptr_q, rd_ptr_d;
  rd_state_e         state_q, state_d;
  logic              out_push_q, out_push_d;
  logic [DATA_W-1:0] out_real_q, out_real_d;
  logic [DATA_W-1:0] out_imag_q, out_imag_d;
  logic              out_last_q, out_last_d;

  logic              wr_en_c;
  logic              load_c;
  logic [LOG2_N-1:0] rd_addr_c;
  logic [SAMP_W-1:0] rd_data_c;

  assign in_stall = full_q[wr_bank_q];
  assign wr_en_c  = in_push && !full_q[wr_bank_q];
  assign out_push = out_push_q;
  assign out_real = out_real_q;
  assign out_imag = out_imag_q;
  assign out_last = out_last_q;

`ifdef FFT_REORDER_BITREV_EN
  fft_bitrev_addr #(.W(LOG2_N)) u_bitrev_addr (
    .addr_in  (rd_ptr_q),
    .addr_out (rd_addr_c)
  );
`else
  assign rd_addr_c = rd_ptr_q;
`endif

  assign rd_data_c = mem_q[rd_bank_q][rd_addr_c];

  // Bank storage needs no reset: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_bank_q][wr_ptr_q] <= {in_real, in_imag};
  end

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    full_d     = full_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    out_push_d = out_push_q;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;
    out_last_d = out_last_q;

    load_c = ((state_q == RD_SEND) || full_q[rd_bank_q]) && (!out_push_q || !out_stall);

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + LOG2_N'(1);
      if (wr_ptr_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (out_push_q && !out_stall) begin
      out_push_d = 1'b0;
      out_last_d = 1'b0;
    end

    // Idle with a full bank loads sample 0 straight away so frames chain without a bubble.
    if (load_c) begin
      out_push_d = 1'b1;
      out_real_d = rd_data_c[SAMP_W-1:DATA_W];
      out_imag_d = rd_data_c[DATA_W-1:0];
      out_last_d = (rd_ptr_q == LAST_IDX);
      rd_ptr_d   = rd_ptr_q + LOG2_N'(1);
      state_d    = RD_SEND;
      if (rd_ptr_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        state_d           = full_q[~rd_bank_q] ? RD_SEND : RD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      full_q     <= '0;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      state_q    <= RD_IDLE;
      out_push_q <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      out_push_q <= out_push_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_reorder.sv
// Self-checking bench for fft_frame_reorder: directed impulse/ramp table, back-to-back,
// stall, reset and randomized traffic against a frame-level reference model.
module tb_fft_frame_reorder;

  localparam int unsigned N    = 16;
  localparam int unsigned W    = 16;
  localparam int unsigned LOG2 = $clog2(N);

  logic         clk = 1'b0;
  logic         reset;
  logic         in_push;
  logic [W-1:0] in_real;
  logic [W-1:0] in_imag;
  logic         in_stall;
  logic         out_push;
  logic [W-1:0] out_real;
  logic [W-1:0] out_imag;
  logic         out_last;
  logic         out_stall;

  always #5 clk = ~clk;

  fft_frame_reorder #(.N_POINTS(N), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_push   (in_push),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_stall  (in_stall),
    .out_push  (out_push),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .out_stall (out_stall)
  );

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
  } samp_t;

  typedef struct {
    string                 name;
    logic [N-1:0][W-1:0]   in_re;
    logic [N-1:0][W-1:0]   exp_re;
  } vec_t;

  samp_t got_q[$];
  samp_t exp_q[$];
  samp_t cur_q[$];
  int    got_cyc[$];
  samp_t mdl_s;
  int    cyc = 0;
  int    pass_cnt = 0;
  int    check_cnt = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Output position k carries input index ref_index(k).
  function automatic int ref_index(input int k);
`ifdef FFT_REORDER_BITREV_EN
    int r = 0;
    int v = k;
    for (int b = 0; b < int'(LOG2); b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
`else
    return k;
`endif
  endfunction

  // Reference model and output collector, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (in_push && !in_stall) begin
        cur_q.push_back('{re: in_real, im: in_imag, last: 1'b0});
        if (cur_q.size() == N) begin
          for (int k = 0; k < int'(N); k++) begin
            mdl_s      = cur_q[ref_index(k)];
            mdl_s.last = (k == int'(N) - 1);
            exp_q.push_back(mdl_s);
          end
          cur_q.delete();
        end
      end
      if (out_push && !out_stall) begin
        got_q.push_back('{re: out_real, im: out_imag, last: out_last});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [W-1:0] re, input logic [W-1:0] im, inout int stalls);
    int guard = 0;
    in_push = 1'b1;
    in_real = re;
    in_imag = im;
    while (in_stall && guard < 300) begin
      stalls++;
      guard++;
      tick();
    end
    if (guard >= 300) check("input_accept_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_outputs(input int n, input string name);
    int guard = 0;
    while (got_q.size() < n && guard < 1000) begin
      guard++;
      tick();
    end
    check({name, "_count"}, got_q.size(), n);
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    cur_q.delete();
    got_cyc.delete();
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].re", name, i), got_q[i].re, exp_q[i].re);
      check($sformatf("%s[%0d].im", name, i), got_q[i].im, exp_q[i].im);
      check($sformatf("%s[%0d].last", name, i), got_q[i].last, exp_q[i].last);
    end
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_in_stall"}, in_stall, 0);
    check({name, "_out_push"}, out_push, 0);
    check({name, "_out_real"}, out_real, 0);
    check({name, "_out_imag"}, out_imag, 0);
    check({name, "_out_last"}, out_last, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[3];
    int   br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int   st;
    int   sent;
    int   guard;
    bit   accepted;

    vecs[0].name = "impulse";
    vecs[0].in_re = '0;
    vecs[0].in_re[0] = 16'h7fff;
    vecs[0].exp_re = '0;
    vecs[0].exp_re[0] = 16'h7fff;
    vecs[1].name = "shifted_impulse";
    vecs[1].in_re = '0;
    vecs[1].in_re[1] = 16'h7fff;
    vecs[1].exp_re = '0;
    vecs[2].name = "ramp";
    for (int i = 0; i < int'(N); i++) vecs[2].in_re[i] = W'(i);
`ifdef FFT_REORDER_BITREV_EN
    vecs[1].exp_re[8] = 16'h7fff;
    for (int i = 0; i < int'(N); i++) vecs[2].exp_re[i] = W'(br[i]);
`else
    vecs[1].exp_re[1] = 16'h7fff;
    for (int i = 0; i < int'(N); i++) vecs[2].exp_re[i] = W'(i);
`endif

    reset = 1'b1;
    in_push = 1'b0;
    in_real = '0;
    in_imag = '0;
    out_stall = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Directed table: impulse, shifted impulse, ramp.
    for (int v = 0; v < 3; v++) begin
      st = 0;
      for (int i = 0; i < int'(N); i++) send_one(vecs[v].in_re[i], '0, st);
      in_push = 1'b0;
      check({vecs[v].name, "_stalls"}, st, 0);
      check({vecs[v].name, "_push_at_last_accept"}, out_push, 0);
      tick();
      check({vecs[v].name, "_push_next_edge"}, out_push, 1);
      wait_outputs(N, vecs[v].name);
      for (int i = 0; i < int'(N) && i < got_q.size(); i++) begin
        check($sformatf("%s[%0d].re", vecs[v].name, i), got_q[i].re, vecs[v].exp_re[i]);
        check($sformatf("%s[%0d].im", vecs[v].name, i), got_q[i].im, 0);
        check($sformatf("%s[%0d].last", vecs[v].name, i), got_q[i].last, (i == int'(N) - 1));
      end
      tick();
      check({vecs[v].name, "_push_drops"}, out_push, 0);
      clear_all();
    end

    // Three back-to-back random frames with no downstream stall.
    st = 0;
    for (int i = 0; i < 3 * int'(N); i++) send_one(W'($urandom), W'($urandom), st);
    in_push = 1'b0;
    check("b2b_in_stall_cycles", st, 0);
    wait_outputs(3 * N, "b2b");
    if (got_cyc.size() == 3 * N) check("b2b_output_span", got_cyc[3*N-1] - got_cyc[0], 3 * N - 1);
    compare_stream("b2b");

    // Downstream stalled: exactly two frames fit, output register holds.
    out_stall = 1'b1;
    st = 0;
    for (int i = 0; i < 2 * int'(N); i++) send_one(W'($urandom), W'($urandom), st);
    in_push = 1'b1;
    check("stall_accepts_before_full", st, 0);
    check("stall_in_stall_after_2N", in_stall, 1);
    repeat (10) tick();
    in_push = 1'b0;
    check("stall_in_stall_held", in_stall, 1);
    check("stall_out_push_held", out_push, 1);
    if (exp_q.size() > 0) check("stall_out_real_held", out_real, exp_q[0].re);
    if (exp_q.size() > 0) check("stall_out_imag_held", out_imag, exp_q[0].im);
    check("stall_nothing_consumed", got_q.size(), 0);
    out_stall = 1'b0;
    st = 0;
    for (int i = 0; i < int'(N); i++) send_one(W'($urandom), W'($urandom), st);
    in_push = 1'b0;
    wait_outputs(3 * N, "stall");
    compare_stream("stall");

    // Reset with a pending output frame and a partial input frame.
    out_stall = 1'b1;
    st = 0;
    for (int i = 0; i < int'(N) + 5; i++) send_one(W'($urandom | 1), W'($urandom), st);
    in_push = 1'b0;
    reset = 1'b1;
    #1;
    check_idle_outputs("reset_async");
    tick();
    check_idle_outputs("reset_held");
    clear_all();
    reset = 1'b0;
    out_stall = 1'b0;
    tick();
    st = 0;
    for (int i = 0; i < int'(N); i++) send_one(W'($urandom), W'($urandom), st);
    in_push = 1'b0;
    check("post_reset_stalls", st, 0);
    wait_outputs(N, "post_reset");
    repeat (20) tick();
    compare_stream("post_reset");

    // Randomized push gaps and downstream stalls.
    sent = 0;
    guard = 0;
    while ((sent < 6 * int'(N) || got_q.size() < 6 * N) && guard < 5000) begin
      out_stall = ($urandom % 10) < 3;
      if (sent < 6 * int'(N) && ($urandom % 4) != 0) begin
        in_push = 1'b1;
        in_real = W'($urandom);
        in_imag = W'($urandom);
      end else begin
        in_push = 1'b0;
      end
      accepted = in_push && !in_stall;
      tick();
      if (accepted) sent++;
      guard++;
    end
    in_push = 1'b0;
    out_stall = 1'b0;
    repeat (5) tick();
    check("rand_accepted", sent, 6 * N);
    compare_stream("rand");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
